// File: rtl/midi_msg_parser_if.sv
// Byte-stream in / framed-message out bundle between the MIDI UART receiver,
// the message parser and the note on/off mux.
interface midi_msg_parser_if;
  logic [7:0]  Rx_Byte;
  logic        Rx_Valid;
  logic [23:0] Msg_Data;
  logic        Msg_Valid;
  logic [7:0]  Err_Count;

  modport master (output Rx_Byte, Rx_Valid, input Msg_Data, Msg_Valid, Err_Count);
  modport slave  (input Rx_Byte, Rx_Valid, output Msg_Data, Msg_Valid, Err_Count);
endinterface

// File: rtl/midi_msg_parser.sv
// Frames raw MIDI bytes into 3-byte channel voice messages with running status,
// real-time passthrough-ignore, SysEx discard and stale-partial timeout.
module midi_msg_parser #(
  parameter int unsigned TIMEOUT_CYCLES = 500000,
  parameter bit          VEL0_IS_OFF    = 1'b1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  midi_msg_parser_if.slave  bus
);

  localparam int unsigned        TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]      TMO_MAX = TW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_D1 = 2'd1,
    WAIT_D2 = 2'd2,
    SYSEX   = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    status_q, status_d;
  logic [7:0]    data1_q, data1_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [23:0]   msg_data_q, msg_data_d;
  logic          msg_valid_q, msg_valid_d;
  logic [7:0]    err_count_q, err_count_d;

  logic          is_rt_s, live_s, two_byte_s, emit_s, err_s;
  logic [23:0]   emit_msg_s;

  // Note On with zero velocity is reported as Note Off; running status is untouched.
  function automatic logic [23:0] vel0_fix(input logic [23:0] m);
    if ((VEL0_IS_OFF == 1'b1) && (m[23:20] == 4'h9) && (m[7:0] == 8'h00)) begin
      return {4'h8, m[19:0]};
    end else begin
      return m;
    end
  endfunction

  // Next-state, message assembly, timeout and error accounting.
  always_comb begin
    state_d     = state_q;
    status_d    = status_q;
    data1_d     = data1_q;
    tmo_d       = tmo_q;
    msg_data_d  = msg_data_q;
    msg_valid_d = 1'b0;
    err_count_d = err_count_q;
    emit_s      = 1'b0;
    err_s       = 1'b0;
    emit_msg_s  = 24'h000000;

    is_rt_s    = (bus.Rx_Byte[7:3] == 5'b11111);
    live_s     = bus.Rx_Valid && !is_rt_s;
    two_byte_s = (status_q[7:4] != 4'hC) && (status_q[7:4] != 4'hD);

    if (live_s) begin
      tmo_d = '0;
      if (bus.Rx_Byte[7] == 1'b1) begin
        // A status byte always re-frames; leaving SysEx needs no special case.
        if (state_q == WAIT_D2) begin
          err_s = 1'b1;
        end else begin
          err_s = 1'b0;
        end
        if (bus.Rx_Byte[7:4] != 4'hF) begin
          status_d = bus.Rx_Byte;
          state_d  = WAIT_D1;
        end else if (bus.Rx_Byte == 8'hF0) begin
          status_d = 8'h00;
          state_d  = SYSEX;
        end else begin
          status_d = 8'h00;
          state_d  = IDLE;
        end
      end else begin
        case (state_q)
          IDLE: begin
            err_s = 1'b1;
          end
          WAIT_D1: begin
            if (two_byte_s) begin
              data1_d = bus.Rx_Byte;
              state_d = WAIT_D2;
            end else begin
              emit_s     = 1'b1;
              emit_msg_s = {status_q, bus.Rx_Byte, 8'h00};
            end
          end
          WAIT_D2: begin
            emit_s     = 1'b1;
            emit_msg_s = {status_q, data1_q, bus.Rx_Byte};
            state_d    = WAIT_D1;
          end
          SYSEX: begin
            state_d = SYSEX;
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end else if (state_q == WAIT_D2) begin
      if (tmo_q >= (TMO_MAX - TW'(1))) begin
        tmo_d   = TMO_MAX;
        state_d = WAIT_D1;
        err_s   = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = tmo_q;
    end

    if (emit_s) begin
      msg_data_d  = vel0_fix(emit_msg_s);
      msg_valid_d = 1'b1;
    end else begin
      msg_valid_d = 1'b0;
    end

    if (err_s && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end else begin
      err_count_d = err_count_q;
    end
  end

  // State and output registers.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      status_q    <= 8'h00;
      data1_q     <= 8'h00;
      tmo_q       <= '0;
      msg_data_q  <= 24'h000000;
      msg_valid_q <= 1'b0;
      err_count_q <= 8'h00;
    end else begin
      state_q     <= state_d;
      status_q    <= status_d;
      data1_q     <= data1_d;
      tmo_q       <= tmo_d;
      msg_data_q  <= msg_data_d;
      msg_valid_q <= msg_valid_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.Msg_Data  = msg_data_q;
  assign bus.Msg_Valid = msg_valid_q;
  assign bus.Err_Count = err_count_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed + randomized bench for midi_msg_parser against a byte-level message model,
// with twin DUTs covering both Note-On-velocity-0 settings.
module tb_midi_msg_parser;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  midi_msg_parser_if bus0();
  midi_msg_parser_if bus1();

  midi_msg_parser #(.TIMEOUT_CYCLES(TMO), .VEL0_IS_OFF(1'b1)) dut0 (
    .Clk(clk), .Rst_n(rst_n), .bus(bus0));
  midi_msg_parser #(.TIMEOUT_CYCLES(TMO), .VEL0_IS_OFF(1'b0)) dut1 (
    .Clk(clk), .Rst_n(rst_n), .bus(bus1));

  // Model state: running status (0 = none), pending first data byte, sysex flag.
  logic [7:0]  m_rs, m_d1;
  bit          m_sx, m_hd1, m_val;
  int          m_idle, m_err;
  logic [23:0] m_raw, m_conv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rs = 8'h00; m_d1 = 8'h00; m_sx = 1'b0; m_hd1 = 1'b0; m_val = 1'b0;
    m_idle = 0; m_err = 0; m_raw = 24'h0; m_conv = 24'h0;
  endtask

  function automatic bit needs_two(input logic [7:0] s);
    return !(s[7:4] == 4'hC || s[7:4] == 4'hD);
  endfunction

  task automatic bump_err();
    if (m_err < 255) m_err++;
  endtask

  task automatic emit(input logic [23:0] m);
    m_val = 1'b1;
    m_raw = m;
    m_conv = (m[23:20] == 4'h9 && m[7:0] == 8'h00) ? {4'h8, m[19:0]} : m;
  endtask

  task automatic model_step(input logic v, input logic [7:0] b);
    m_val = 1'b0;
    if (v && b < 8'hF8) begin
      m_idle = 0;
      if (b[7]) begin
        if (m_rs != 8'h00 && m_hd1) bump_err();
        m_hd1 = 1'b0;
        m_sx = (b == 8'hF0);
        m_rs = (b < 8'hF0) ? b : 8'h00;
      end else if (m_sx) begin
        // sysex payload dropped silently
      end else if (m_rs == 8'h00) begin
        bump_err();
      end else if (!needs_two(m_rs)) begin
        emit({m_rs, b, 8'h00});
      end else if (!m_hd1) begin
        m_d1 = b;
        m_hd1 = 1'b1;
      end else begin
        emit({m_rs, m_d1, b});
        m_hd1 = 1'b0;
      end
    end else if (m_rs != 8'h00 && m_hd1) begin
      m_idle++;
      if (m_idle >= TMO) begin
        m_hd1 = 1'b0;
        bump_err();
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    bus0.Rx_Valid = v; bus0.Rx_Byte = b;
    bus1.Rx_Valid = v; bus1.Rx_Byte = b;
    model_step(v, b);
    @(posedge clk);
    @(negedge clk);
    bus0.Rx_Valid = 1'b0;
    bus1.Rx_Valid = 1'b0;
    chk("valid", {31'd0, bus0.Msg_Valid}, {31'd0, m_val});
    chk("valid_v0", {31'd0, bus1.Msg_Valid}, {31'd0, m_val});
    chk("data", {8'd0, bus0.Msg_Data}, {8'd0, m_conv});
    chk("data_v0", {8'd0, bus1.Msg_Data}, {8'd0, m_raw});
    chk("err", {24'd0, bus0.Err_Count}, m_err);
    chk("err_v0", {24'd0, bus1.Err_Count}, m_err);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
    step(1'b0, 8'h00);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus0.Rx_Valid = 1'b0; bus1.Rx_Valid = 1'b0;
    #2;
    chk("rst_data", {8'd0, bus0.Msg_Data}, 32'd0);
    chk("rst_valid", {31'd0, bus0.Msg_Valid}, 32'd0);
    chk("rst_err", {24'd0, bus0.Err_Count}, 32'd0);
    chk("rst_err_v0", {24'd0, bus1.Err_Count}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [7:0] rnd_byte();
    int r;
    r = $urandom_range(99, 0);
    if (r < 42)      return 8'($urandom_range(127, 0));
    else if (r < 70) return 8'($urandom_range(239, 128));
    else if (r < 80) return 8'($urandom_range(255, 248));
    else if (r < 87) return 8'hF0;
    else if (r < 93) return 8'hF7;
    else             return 8'($urandom_range(246, 241));
  endfunction

  initial begin
    bus0.Rx_Valid = 1'b0; bus0.Rx_Byte = 8'h00;
    bus1.Rx_Valid = 1'b0; bus1.Rx_Byte = 8'h00;
    model_reset();
    do_reset();

    // T1 basic note on
    send(8'h90); send(8'h3C); step(1'b1, 8'h64);
    chk("t1_valid", {31'd0, bus0.Msg_Valid}, 32'd1);
    chk("t1_data", {8'd0, bus0.Msg_Data}, 32'h903C64);
    idle(1);

    // T2 running status and velocity-0 conversion
    send(8'h3E); send(8'h40);
    chk("t2_data", {8'd0, bus0.Msg_Data}, 32'h903E40);
    send(8'h3C); send(8'h00);
    chk("t2_vel0", {8'd0, bus0.Msg_Data}, 32'h803C00);
    chk("t2_vel0_raw", {8'd0, bus1.Msg_Data}, 32'h903C00);

    // T3 real-time interleaved mid-message
    send(8'h91); send(8'hF8); send(8'h45); send(8'hFE); send(8'h7F);
    chk("t3_data", {8'd0, bus0.Msg_Data}, 32'h91457F);
    chk("t3_err", {24'd0, bus0.Err_Count}, 32'd0);

    // T4 one-data-byte message, then sysex and an orphan data byte
    send(8'hC2); send(8'h05);
    chk("t4_data", {8'd0, bus0.Msg_Data}, 32'hC20500);
    send(8'hF0); send(8'h01); send(8'h02); send(8'hF7); send(8'h40);
    chk("t4_err", {24'd0, bus0.Err_Count}, 32'd1);
    chk("t4_hold", {8'd0, bus0.Msg_Data}, 32'hC20500);

    // T5 abort by new status, then timeout of a partial message
    do_reset();
    send(8'h92); send(8'h30); send(8'h93); send(8'h31); send(8'h10);
    chk("t5_data", {8'd0, bus0.Msg_Data}, 32'h933110);
    chk("t5_err", {24'd0, bus0.Err_Count}, 32'd1);
    send(8'h92); send(8'h30);
    idle(TMO - 3);
    chk("t5_pre_tmo", {24'd0, bus0.Err_Count}, 32'd1);
    idle(5);
    chk("t5_tmo", {24'd0, bus0.Err_Count}, 32'd2);
    send(8'h31); send(8'h10);
    chk("t5_after", {8'd0, bus0.Msg_Data}, 32'h923110);

    // T6 reset mid-message
    do_reset();
    send(8'h90); send(8'h3C);
    do_reset();
    send(8'h64);
    chk("t6_err", {24'd0, bus0.Err_Count}, 32'd1);
    chk("t6_data", {8'd0, bus0.Msg_Data}, 32'd0);

    // error counter saturation with back-to-back orphan data bytes
    for (int i = 0; i < 300; i++) step(1'b1, 8'h11);
    chk("sat_err", {24'd0, bus0.Err_Count}, 32'd255);

    // randomized stream with random gaps, occasionally long enough to time out
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      step(1'b1, rnd_byte());
      if ($urandom_range(99, 0) < 4) idle(TMO + 2);
      else idle($urandom_range(3, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
